pm_sample_feeder: RTL and testbench

Upstream feeder for the carrier NCO. It buffers 16-bit phase-modulation samples from the DSP/USB path in a small FIFO and releases one sample per interpolation period of 2^LOG2_INTERP clocks. Between samples it linearly ramps the phase along the shortest modular path, so the NCO `phaseOffset` input moves smoothly instead of stepping. It also owns the NCO frequency word, which changes only on sample boundaries, and the NCO enable.

---
 rtl/nexrig_pkg.sv | 19 +
 rtl/pm_sample_feeder_if.sv | 12 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/pm_sample_feeder.sv | 155 +++++++++++++++
 tb/tb_pm_sample_feeder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/nexrig_pkg.sv
// Shared types and widths for the NCO feed path.
package nexrig_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } pm_state_t;

  localparam int PHASE_W = 16;
  localparam int FREQ_W  = 32;

  // Modular phase difference; the result is read as signed to pick the shortest path.
  function automatic logic [PHASE_W-1:0] phaseDiff(input logic [PHASE_W-1:0] a,
                                                   input logic [PHASE_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/pm_sample_feeder_if.sv
// Valid/ready sample stream from the DSP/USB path into the phase feeder.
interface pm_sample_feeder_if;
  import nexrig_pkg::*;

  logic [PHASE_W-1:0] sampleData;
  logic               sampleValid;
  logic               sampleReady;

  modport master (output sampleData, output sampleValid, input  sampleReady);
  modport slave  (input  sampleData, input  sampleValid, output sampleReady);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO over a register array; the head entry is presented directly so
// a pop sees its data in the same cycle, and a push is visible one cycle later.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     flush,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     rdEn,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [LVL_W-1:0] count;
  logic             push;
  logic             pop;

  assign full   = (count == LVL_W'(DEPTH));
  assign empty  = (count == '0);
  assign push   = wrEn && !full && !flush;
  assign pop    = rdEn && !empty && !flush;
  assign rdData = mem[rdPtr];
  assign level  = count;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/pm_sample_feeder.sv
// Buffers phase samples, releases one per 2^LOG2_INTERP clocks and ramps the NCO
// phase offset linearly between them; also owns the NCO frequency word and enable.
//
//   state | meaning
//   IDLE  | disabled, FIFO flushed, interpolator cleared
//   PRIME | accepting samples until PRIME_LEVEL are buffered
//   RUN   | ticking, popping samples and ramping phaseOffset
module pm_sample_feeder
  import nexrig_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int LOG2_INTERP = 10,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         enable,
  pm_sample_feeder_if.slave            sampleIf,
  input  logic [FREQ_W-1:0]            freqWord,
  input  logic                         freqLoad,
  input  logic                         underrunClear,
  output logic [FREQ_W-1:0]            freqControl,
  output logic [PHASE_W-1:0]           phaseOffset,
  output logic                         ncoEnable,
  output logic                         underrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifoLevel
);

  localparam int ACC_W = PHASE_W + LOG2_INTERP;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  pm_state_t              state;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       deltaReg;
  logic [PHASE_W-1:0]     target;
  logic [LOG2_INTERP-1:0] cnt;
  logic [FREQ_W-1:0]      freqShadow;
  logic                   freqPending;

  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [PHASE_W-1:0]     fifoRdData;
  logic                   pushReq;
  logic                   popReq;
  logic                   flush;
  logic                   tick;
  logic [PHASE_W-1:0]     diff;

  assign sampleIf.sampleReady = (state != IDLE) && !fifoFull;
  assign pushReq = sampleIf.sampleValid && sampleIf.sampleReady;
  assign tick    = (state == RUN) && (cnt == '0);
  assign popReq  = tick && !fifoEmpty;
  // Flushing on !enable as well empties the FIFO in the same cycle the FSM drops to IDLE.
  assign flush   = (state == IDLE) || !enable;
  assign diff    = phaseDiff(fifoRdData, target);

  sync_fifo #(
    .WIDTH (PHASE_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk    (clk),
    .rstN   (rstN),
    .flush  (flush),
    .wrEn   (pushReq),
    .wrData (sampleIf.sampleData),
    .rdEn   (popReq),
    .rdData (fifoRdData),
    .level  (fifoLevel),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      ncoEnable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ncoEnable <= 1'b0;
          if (enable) state <= PRIME;
        end
        PRIME: begin
          if (!enable) begin
            state <= IDLE;
          end else if (fifoLevel >= LVL_W'(PRIME_LEVEL)) begin
            state     <= RUN;
            ncoEnable <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state     <= IDLE;
            ncoEnable <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          ncoEnable <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc         <= '0;
      deltaReg    <= '0;
      target      <= '0;
      cnt         <= '0;
      phaseOffset <= '0;
    end else begin
      phaseOffset <= (state == RUN && enable) ? acc[ACC_W-1:LOG2_INTERP] : '0;
      if (state != RUN) begin
        acc      <= '0;
        deltaReg <= '0;
        target   <= '0;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        // The add uses the pre-tick delta so each ramp is exactly 2^LOG2_INTERP steps.
        acc <= acc + deltaReg;
        if (tick) begin
          if (!fifoEmpty) begin
            deltaReg <= {{LOG2_INTERP{diff[PHASE_W-1]}}, diff};
            target   <= fifoRdData;
          end else begin
            deltaReg <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      underrun    <= 1'b0;
      freqShadow  <= '0;
      freqPending <= 1'b0;
      freqControl <= '0;
    end else begin
      if (tick && fifoEmpty)  underrun <= 1'b1;
      else if (underrunClear) underrun <= 1'b0;

      if (freqLoad) begin
        freqShadow  <= freqWord;
        freqPending <= 1'b1;
      end else if (freqPending && (state != RUN || tick)) begin
        freqControl <= freqShadow;
        freqPending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pm_sample_feeder.sv
// Directed bench: dutA (LOG2_INTERP=2, PRIME_LEVEL=1) covers ramp/wrap/underrun/freq/disable/reset,
// dutB (depth 8, PRIME_LEVEL=8) covers priming and backpressure.
module tb_pm_sample_feeder;
  import nexrig_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        enableA, freqLoadA, underrunClearA;
  logic [31:0] freqWordA, freqControlA;
  logic [15:0] phaseA;
  logic        ncoEnableA, underrunA;
  logic [4:0]  levelA;

  logic        enableB, freqLoadB, underrunClearB;
  logic [31:0] freqWordB, freqControlB;
  logic [15:0] phaseB;
  logic        ncoEnableB, underrunB;
  logic [3:0]  levelB;

  pm_sample_feeder_if ifA ();
  pm_sample_feeder_if ifB ();

  pm_sample_feeder #(.FIFO_DEPTH(16), .LOG2_INTERP(2), .PRIME_LEVEL(1)) dutA (
    .clk(clk), .rstN(rstN), .enable(enableA), .sampleIf(ifA),
    .freqWord(freqWordA), .freqLoad(freqLoadA), .underrunClear(underrunClearA),
    .freqControl(freqControlA), .phaseOffset(phaseA), .ncoEnable(ncoEnableA),
    .underrun(underrunA), .fifoLevel(levelA)
  );

  pm_sample_feeder #(.FIFO_DEPTH(8), .LOG2_INTERP(2), .PRIME_LEVEL(8)) dutB (
    .clk(clk), .rstN(rstN), .enable(enableB), .sampleIf(ifB),
    .freqWord(freqWordB), .freqLoad(freqLoadB), .underrunClear(underrunClearB),
    .freqControl(freqControlB), .phaseOffset(phaseB), .ncoEnable(ncoEnableB),
    .underrun(underrunB), .fifoLevel(levelB)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] wrapExp [5];

  initial begin
    wrapExp[0] = 16'hFF00; wrapExp[1] = 16'hFF80; wrapExp[2] = 16'h0000;
    wrapExp[3] = 16'h0080; wrapExp[4] = 16'h0100;

    rstN = 1'b0;
    enableA = 0; freqLoadA = 0; underrunClearA = 0; freqWordA = '0;
    enableB = 0; freqLoadB = 0; underrunClearB = 0; freqWordB = '0;
    ifA.sampleValid = 0; ifA.sampleData = '0;
    ifB.sampleValid = 0; ifB.sampleData = '0;

    cyc(2);
    check("rst A freqControl", freqControlA, 32'd0);
    check("rst A phaseOffset", 32'(phaseA), 32'd0);
    check("rst A ncoEnable",   32'(ncoEnableA), 32'd0);
    check("rst A underrun",    32'(underrunA), 32'd0);
    check("rst A sampleReady", 32'(ifA.sampleReady), 32'd0);
    check("rst A fifoLevel",   32'(levelA), 32'd0);
    check("rst B sampleReady", 32'(ifB.sampleReady), 32'd0);
    check("rst B fifoLevel",   32'(levelB), 32'd0);
    rstN = 1'b1;
    cyc();

    // ---- dutB: prime and backpressure ----
    enableB = 1;
    cyc();                                         // b1: PRIME
    check("B ready in PRIME", 32'(ifB.sampleReady), 32'd1);
    freqWordB = 32'hCAFEF00D; freqLoadB = 1;
    ifB.sampleValid = 1; ifB.sampleData = 16'h0001;
    cyc();                                         // b2
    freqLoadB = 0;
    check("B freq before apply", freqControlB, 32'd0);
    for (int i = 2; i <= 7; i++) begin
      ifB.sampleData = 16'(i);
      cyc();
      if (i == 2) check("B freq applied in PRIME", freqControlB, 32'hCAFEF00D);
    end
    // b8: seven samples buffered
    check("B level 7", 32'(levelB), 32'd7);
    check("B no RUN before 8th", 32'(ncoEnableB), 32'd0);
    check("B ready at 7", 32'(ifB.sampleReady), 32'd1);
    ifB.sampleData = 16'h0008;
    cyc();                                         // b9
    ifB.sampleValid = 0;
    check("B level full", 32'(levelB), 32'd8);
    check("B ready when full", 32'(ifB.sampleReady), 32'd0);
    check("B ncoEnable lag", 32'(ncoEnableB), 32'd0);
    cyc();                                         // b10: first RUN cycle
    check("B ncoEnable in RUN", 32'(ncoEnableB), 32'd1);
    check("B level before pop", 32'(levelB), 32'd8);
    cyc();                                         // b11
    check("B level after pop", 32'(levelB), 32'd7);
    check("B ready after pop", 32'(ifB.sampleReady), 32'd1);
    enableB = 0;
    cyc();                                         // b12
    check("B disable flush", 32'(levelB), 32'd0);
    check("B disable ncoEnable", 32'(ncoEnableB), 32'd0);

    // ---- dutA: ramp ----
    enableA = 1;                                   // c0
    cyc();                                         // c1
    check("A ready in PRIME", 32'(ifA.sampleReady), 32'd1);
    ifA.sampleValid = 1; ifA.sampleData = 16'h0400;
    cyc();                                         // c2
    check("A ncoEnable in PRIME", 32'(ncoEnableA), 32'd0);
    ifA.sampleData = 16'h0800;
    cyc();                                         // c3: first tick
    ifA.sampleValid = 0;
    check("A ncoEnable rise", 32'(ncoEnableA), 32'd1);
    check("A level at first tick", 32'(levelA), 32'd2);
    cyc();                                         // c4
    check("A phase c4", 32'(phaseA), 32'd0);
    cyc();                                         // c5
    check("A phase c5", 32'(phaseA), 32'd0);
    cyc();                                         // c6
    for (int k = 1; k <= 8; k++) begin             // cycles c6..c13
      check("A ramp", 32'(phaseA), 32'(k * 256));
      if (k == 6) begin                            // c11: empty tick
        check("A underrun before", 32'(underrunA), 32'd0);
        underrunClearA = 1;
      end
      if (k == 7) begin
        check("A underrun set wins", 32'(underrunA), 32'd1);
        underrunClearA = 0;
      end
      if (k == 8) underrunClearA = 1;
      cyc();
    end
    // c14
    underrunClearA = 0;
    check("A underrun cleared", 32'(underrunA), 32'd0);
    check("A phase holds target", 32'(phaseA), 32'h0800);
    ifA.sampleValid = 1; ifA.sampleData = 16'hFF00;
    cyc();                                         // c15
    ifA.sampleData = 16'h0100;
    cyc();                                         // c16
    ifA.sampleValid = 0;
    cyc(2);                                        // c18
    check("A descend c18", 32'(phaseA), 32'h05C0);
    cyc(3);                                        // c21
    for (int k = 0; k < 5; k++) begin              // c21..c25
      check("A wrap", 32'(phaseA), 32'(wrapExp[k]));
      if (k == 3) begin freqWordA = 32'h12345678; freqLoadA = 1; end
      if (k == 4) freqLoadA = 0;
      cyc();
    end
    // c26
    cyc();                                         // c27: tick
    check("A freq before tick", freqControlA, 32'd0);
    cyc();                                         // c28
    check("A freq after tick", freqControlA, 32'h12345678);
    cyc();                                         // c29
    freqWordA = 32'hAAAA0001; freqLoadA = 1;
    cyc();                                         // c30
    freqWordA = 32'h55550002;
    cyc();                                         // c31: tick
    freqLoadA = 0;
    check("A freq held to tick", freqControlA, 32'h12345678);
    cyc();                                         // c32
    check("A freq last load wins", freqControlA, 32'h55550002);

    // ---- dutA: disable mid-ramp ----
    ifA.sampleValid = 1; ifA.sampleData = 16'h4100;
    cyc();                                         // c33
    ifA.sampleValid = 0;
    cyc(3);                                        // c36
    ifA.sampleValid = 1; ifA.sampleData = 16'h5000;
    cyc();                                         // c37
    ifA.sampleValid = 0;
    cyc();                                         // c38
    check("A mid-ramp phase", 32'(phaseA), 32'h1100);
    check("A level before disable", 32'(levelA), 32'd1);
    enableA = 0;
    cyc();                                         // c39
    check("A disable ncoEnable", 32'(ncoEnableA), 32'd0);
    check("A disable phase", 32'(phaseA), 32'd0);
    check("A disable flush", 32'(levelA), 32'd0);
    check("A disable ready", 32'(ifA.sampleReady), 32'd0);
    check("A underrun sticky", 32'(underrunA), 32'd1);

    // ---- dutA: async reset mid-ramp ----
    enableA = 1;
    cyc();                                         // c40
    ifA.sampleValid = 1; ifA.sampleData = 16'h2000;
    cyc();                                         // c41
    ifA.sampleValid = 0;
    cyc(4);                                        // c45
    ifA.sampleValid = 1; ifA.sampleData = 16'h3000;
    cyc();                                         // c46
    ifA.sampleValid = 0;
    check("A ramp before reset", 32'(phaseA), 32'h1000);
    check("A level before reset", 32'(levelA), 32'd1);
    #3 rstN = 1'b0;
    #1;
    check("A async rst freqControl", freqControlA, 32'd0);
    check("A async rst phase", 32'(phaseA), 32'd0);
    check("A async rst ncoEnable", 32'(ncoEnableA), 32'd0);
    check("A async rst underrun", 32'(underrunA), 32'd0);
    check("A async rst level", 32'(levelA), 32'd0);
    check("A async rst ready", 32'(ifA.sampleReady), 32'd0);
    cyc();
    rstN = 1'b1;
    cyc();
    check("A restart via PRIME", 32'(ifA.sampleReady), 32'd1);
    check("A restart ncoEnable", 32'(ncoEnableA), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
